fp_tree_accum: RTL and testbench



---
 rtl/fp_tree_accum.sv | 175 +++++++++++++++++
 tb/tb_fp_tree_accum.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fp_tree_accum.sv
// FP32 adder-tree accumulator: registered pairwise reduction, grouped accumulation with bias, optional ReLU.
// Define FP_TREE_ACCUM_RELU_EN to clamp negative results to +0.0; otherwise the raw accumulator is output.
module fp_tree_accum #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN = 16,
    localparam int LEVELS = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [DATA_WIDTH*NUM_IN-1:0] i_data,
    input  logic                         i_first,
    input  logic                         i_last,
    input  logic [DATA_WIDTH-1:0]        i_bias,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_err
);

    localparam int NODES = NUM_IN - 1;

    // Round-to-nearest-even adder; subnormal operands and results are flushed to signed zero.
    function automatic logic [DATA_WIDTH-1:0] add_fp(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] x, y;
        logic [7:0]  ex, ey;
        logic [26:0] mx, my, mask;
        logic [27:0] s;
        logic [24:0] rnd;
        logic        sgn, up;
        int          d, e;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        ex  = x[30:23];
        ey  = y[30:23];
        sgn = x[31];
        add_fp = '0;
        if (ex == 8'hFF) begin
            if (x[22:0] != 23'd0)                   add_fp = x | 32'h0040_0000;
            else if (ey == 8'hFF && x[31] != y[31]) add_fp = 32'h7FC0_0000;
            else                                    add_fp = x;
        end else if (ex == 8'd0) begin
            add_fp = {x[31] & y[31], 31'b0};
        end else if (ey == 8'd0) begin
            add_fp = x;
        end else begin
            d  = int'(ex) - int'(ey);
            mx = {1'b1, x[22:0], 3'b000};
            my = {1'b1, y[22:0], 3'b000};
            if (d > 26) begin
                my = 27'd1;
            end else begin
                mask = (27'd1 << d) - 27'd1;
                my   = (my >> d) | {26'd0, |(my & mask)};
            end
            if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
            else                s = {1'b0, mx} - {1'b0, my};
            e = int'(ex);
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 1;
            end
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && s != 28'd0) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
            up  = s[2] & (s[1] | s[0] | s[3]);
            rnd = {1'b0, s[26:3]} + {24'd0, up};
            if (rnd[24]) begin
                rnd = rnd >> 1;
                e   = e + 1;
            end
            if (s == 28'd0)    add_fp = '0;
            else if (e <= 0)   add_fp = {sgn, 31'b0};
            else if (e >= 255) add_fp = {sgn, 8'hFF, 23'b0};
            else               add_fp = {sgn, e[7:0], rnd[22:0]};
        end
    endfunction

`ifdef FP_TREE_ACCUM_RELU_EN
    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v);
        relu = v[DATA_WIDTH-1] ? '0 : v;
    endfunction
`endif

    logic [DATA_WIDTH*NODES-1:0]         r_tree;
    logic [LEVELS:1]                     r_vld_p, r_first_p, r_last_p;
    logic [DATA_WIDTH-1:0]               r_bias_p [1:LEVELS];
    logic [DATA_WIDTH-1:0]               r_acc, r_odata;
    logic                                r_pend, r_ovld, r_open, r_err;

    logic [DATA_WIDTH*(2*NUM_IN-1)-1:0]  w_all;
    logic [DATA_WIDTH*NODES-1:0]         w_tree_nxt;
    logic [NODES-1:0]                    w_node_ld;
    logic [LEVELS:0]                     w_vld, w_first, w_last;
    logic [DATA_WIDTH-1:0]               w_bias [0:LEVELS];
    logic [DATA_WIDTH-1:0]               w_sum;
    logic                                w_first0, w_err0;

    // Stage s occupies words [2N-2*(N>>s)-N .. ] of r_tree; w_all prepends the input beat as stage 0.
    assign w_all = {r_tree, i_data};
    assign w_sum = w_all[DATA_WIDTH*(2*NUM_IN-2) +: DATA_WIDTH];

    for (genvar s = 1; s <= LEVELS; s++) begin : g_lvl
        localparam int CNT = NUM_IN >> s;
        localparam int SRC = 2*NUM_IN - 4*CNT;
        localparam int DST = NUM_IN - 2*CNT;
        for (genvar j = 0; j < CNT; j++) begin : g_node
            assign w_tree_nxt[DATA_WIDTH*(DST+j) +: DATA_WIDTH] =
                add_fp(w_all[DATA_WIDTH*(SRC+2*j) +: DATA_WIDTH],
                       w_all[DATA_WIDTH*(SRC+2*j+1) +: DATA_WIDTH]);
            assign w_node_ld[DST+j] = w_vld[s-1];
        end
    end

    // A non-first beat outside a group opens one with zero bias; a first beat inside a group restarts it.
    assign w_first0 = i_first | ~r_open;
    assign w_err0   = i_valid & (i_first == r_open);

    always_comb begin
        w_vld   = {r_vld_p, i_valid};
        w_first = {r_first_p, w_first0};
        w_last  = {r_last_p, i_last};
        w_bias[0] = i_first ? i_bias : '0;
        for (int s = 1; s <= LEVELS; s++) w_bias[s] = r_bias_p[s];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tree    <= '0;
            r_vld_p   <= '0;
            r_first_p <= '0;
            r_last_p  <= '0;
            for (int s = 1; s <= LEVELS; s++) r_bias_p[s] <= '0;
            r_acc     <= '0;
            r_pend    <= 1'b0;
            r_ovld    <= 1'b0;
            r_odata   <= '0;
            r_open    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Tree stages 1..LEVELS
            for (int n = 0; n < NODES; n++) begin
                if (w_node_ld[n]) r_tree[DATA_WIDTH*n +: DATA_WIDTH] <= w_tree_nxt[DATA_WIDTH*n +: DATA_WIDTH];
            end
            for (int s = 1; s <= LEVELS; s++) begin
                r_vld_p[s] <= w_vld[s-1];
                if (w_vld[s-1]) begin
                    r_first_p[s] <= w_first[s-1];
                    r_last_p[s]  <= w_last[s-1];
                    r_bias_p[s]  <= w_bias[s-1];
                end
            end
            if (i_valid) r_open <= ~i_last;
            if (w_err0)  r_err  <= 1'b1;
            // Accumulate stage
            if (w_vld[LEVELS]) r_acc <= add_fp(w_first[LEVELS] ? w_bias[LEVELS] : r_acc, w_sum);
            r_pend <= w_vld[LEVELS] & w_last[LEVELS];
            // Output stage
            r_ovld <= r_pend;
`ifdef FP_TREE_ACCUM_RELU_EN
            if (r_pend) r_odata <= relu(r_acc);
`else
            if (r_pend) r_odata <= r_acc;
`endif
        end
    end

    assign o_valid = r_ovld;
    assign o_data  = r_odata;
    assign o_err   = r_err;

endmodule

// File: tb/tb_fp_tree_accum.sv
// Directed bench for fp_tree_accum (NUM_IN=16); expectations follow FP_TREE_ACCUM_RELU_EN when defined.
module tb_fp_tree_accum;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid, i_first, i_last;
    logic [511:0] i_data;
    logic [31:0]  i_bias;
    logic         o_valid, o_err;
    logic [31:0]  o_data;

    int vectors = 0;
    int miscompares = 0;

    fp_tree_accum #(.DATA_WIDTH(32), .NUM_IN(16)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_first(i_first),
        .i_last(i_last), .i_bias(i_bias), .o_valid(o_valid), .o_data(o_data), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat_vec(input logic [511:0] d, input logic f, input logic l, input logic [31:0] b);
        i_valid = 1'b1; i_data = d; i_first = f; i_last = l; i_bias = b;
        @(posedge clk); #1;
        i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    endtask

    task automatic beat(input logic [31:0] w, input logic f, input logic l, input logic [31:0] b);
        beat_vec({16{w}}, f, l, b);
    endtask

    task automatic wait_pulse(output logic [31:0] d, output int n);
        int k;
        k = 0; n = -1; d = '0;
        while (n < 0 && k < 20) begin
            @(negedge clk);
            k++;
            if (o_valid) begin n = k; d = o_data; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [31:0] d;
    int          n, cnt;
    logic [31:0] exp_neg16, exp_neg4;

    initial begin
`ifdef FP_TREE_ACCUM_RELU_EN
        exp_neg16 = 32'h0000_0000;
        exp_neg4  = 32'h0000_0000;
`else
        exp_neg16 = 32'hC180_0000;
        exp_neg4  = 32'hC080_0000;
`endif
        rst = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_data = '0; i_bias = '0;
        @(negedge clk);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_data", o_data, 32'd0);
        chk("reset_err", {31'd0, o_err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // single beat, bias 2.0
        beat(32'h3F80_0000, 1'b1, 1'b1, 32'h4000_0000);
        wait_pulse(d, n);
        chk("t1_latency", n, 32'd6);
        chk("t1_data", d, 32'h4190_0000);
        chk("t1_err", {31'd0, o_err}, 32'd0);
        @(negedge clk);
        chk("t1_pulse_width", {31'd0, o_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_hold", o_data, 32'h4190_0000);

        // three beats with a bubble before the last
        beat(32'h3F80_0000, 1'b1, 1'b0, 32'h0);
        beat(32'h3F80_0000, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 beat(32'h3F80_0000, 1'b0, 1'b1, 32'h0);
        wait_pulse(d, n);
        chk("t2_latency", n, 32'd6);
        chk("t2_data", d, 32'h4240_0000);

        // negative sum
        beat(32'hBF80_0000, 1'b1, 1'b1, 32'h0);
        wait_pulse(d, n);
        chk("t3_data", d, exp_neg16);

        // four back-to-back single-beat groups
        beat(32'h3F80_0000, 1'b1, 1'b1, 32'h0);
        beat(32'h4000_0000, 1'b1, 1'b1, 32'h0);
        beat(32'h0000_0000, 1'b1, 1'b1, 32'h0);
        beat(32'h3F80_0000, 1'b1, 1'b1, 32'h0);
        wait_pulse(d, n);
        chk("t4_latency", n, 32'd3);
        chk("t4_data0", d, 32'h4180_0000);
        @(negedge clk);
        chk("t4_valid1", {31'd0, o_valid}, 32'd1);
        chk("t4_data1", o_data, 32'h4200_0000);
        @(negedge clk);
        chk("t4_valid2", {31'd0, o_valid}, 32'd1);
        chk("t4_data2", o_data, 32'h0000_0000);
        @(negedge clk);
        chk("t4_valid3", {31'd0, o_valid}, 32'd1);
        chk("t4_data3", o_data, 32'h4180_0000);
        @(negedge clk);
        chk("t4_after", {31'd0, o_valid}, 32'd0);
        chk("t4_err", {31'd0, o_err}, 32'd0);

        // ramp 0..15 -> 120.0
        beat_vec({32'h4170_0000, 32'h4160_0000, 32'h4150_0000, 32'h4140_0000,
                  32'h4130_0000, 32'h4120_0000, 32'h4110_0000, 32'h4100_0000,
                  32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000, 32'h4080_0000,
                  32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0000},
                 1'b1, 1'b1, 32'h0);
        wait_pulse(d, n);
        chk("ramp_data", d, 32'h42F0_0000);

        // alternating 1.0 / -0.5 plus bias 0.25 -> 4.25
        beat_vec({8{32'hBF00_0000, 32'h3F80_0000}}, 1'b1, 1'b1, 32'h3E80_0000);
        wait_pulse(d, n);
        chk("mixed_data", d, 32'h4088_0000);

        // bias -20 pulls sum 16 to -4
        beat(32'h3F80_0000, 1'b1, 1'b1, 32'hC1A0_0000);
        wait_pulse(d, n);
        chk("negbias_data", d, exp_neg4);

        // reset in the middle of a group
        beat(32'h3F80_0000, 1'b1, 1'b0, 32'h0);
        beat(32'h3F80_0000, 1'b0, 1'b0, 32'h0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("t5_rst_data", o_data, 32'd0);
        chk("t5_rst_err", {31'd0, o_err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_valid) cnt++;
        end
        chk("t5_no_output", cnt, 32'd0);
        beat(32'h3F80_0000, 1'b1, 1'b1, 32'h0);
        wait_pulse(d, n);
        chk("t5_latency", n, 32'd6);
        chk("t5_data", d, 32'h4180_0000);
        chk("t5_err", {31'd0, o_err}, 32'd0);

        // non-first beat outside a group: bias ignored, error raised
        beat(32'h3F80_0000, 1'b0, 1'b1, 32'h4000_0000);
        wait_pulse(d, n);
        chk("t6_data", d, 32'h4180_0000);
        chk("t6_err", {31'd0, o_err}, 32'd1);
        repeat (5) @(negedge clk);
        chk("t6_err_sticky", {31'd0, o_err}, 32'd1);

        // first beat while a group is open restarts the group
        do_reset();
        @(negedge clk);
        chk("t7_err_cleared", {31'd0, o_err}, 32'd0);
        beat(32'h3F80_0000, 1'b1, 1'b0, 32'h4000_0000);
        beat(32'h4000_0000, 1'b1, 1'b1, 32'h3F80_0000);
        wait_pulse(d, n);
        chk("t7_latency", n, 32'd6);
        chk("t7_data", d, 32'h4204_0000);
        chk("t7_err", {31'd0, o_err}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
